// File: rtl/rf_snapshot_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package    : rf_pkg
// Description: Shared widths and the read-walker state type for the
//              register-file snapshot reader.
// Revision   : 1.0
// ============================================================================
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } rf_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_snapshot_reader_addr_counter.sv
`default_nettype none
// ============================================================================
// Module     : rf_addr_counter
// Description: Walk-address counter. Loads the first address and latches the
//              last address together, increments with natural wrap, and flags
//              when the current address is the last one of the range.
// Revision   : 1.0
// ============================================================================
module rf_addr_counter
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] first_i,
  input  logic [ADDR_W-1:0] last_i,
  output logic [ADDR_W-1:0] cur_o,
  output logic              at_last_o
);

  localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;

  // Next-state: load wins over increment; increment wraps modulo 2^ADDR_W.
  always_comb begin
    cur_d  = cur_q;
    last_d = last_q;
    if (load_i) begin
      cur_d  = first_i;
      last_d = last_i;
    end else if (inc_i) begin
      cur_d  = cur_q + C_ONE;
    end
  end

  // Counter and range-end registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      last_q <= '0;
    end else begin
      cur_q  <= cur_d;
      last_q <= last_d;
    end
  end

  assign cur_o     = cur_q;
  assign at_last_o = (cur_q == last_q);

endmodule
`default_nettype wire

// File: rtl/rf_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module     : rf_snapshot_reader
// Description: Walks a register-file address range on START and streams each
//              value, tagged with its address, over a valid/ready byte port.
//              Read-only towards the register file.
// Revision   : 1.0
// ============================================================================
module rf_snapshot_reader
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] FIRST_ADR,
  input  logic [ADDR_W-1:0] LAST_ADR,
  output logic [ADDR_W-1:0] RD_ADR,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [DATA_W-1:0] TX_DATA,
  output logic [ADDR_W-1:0] TX_ADR,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              BUSY,
  output logic              DONE
);

  rf_rd_state_t      state_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [ADDR_W-1:0] tx_adr_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] w_cur;
  logic              w_at_last;
  logic              w_load;
  logic              w_inc;

  // Range is latched only on an accepted START (ABORT beats START in IDLE);
  // the address advances only on a handshake that is not the final byte.
  assign w_load = (state_q == IDLE) && START && !ABORT;
  assign w_inc  = (state_q == SEND) && !ABORT && TX_READY && !w_at_last;

  rf_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk       (clk),
    .rst_n     (RST_N),
    .load_i    (w_load),
    .inc_i     (w_inc),
    .first_i   (FIRST_ADR),
    .last_i    (LAST_ADR),
    .cur_o     (w_cur),
    .at_last_o (w_at_last)
  );

  // Walker FSM with registered outputs; ABORT in any active state returns to
  // IDLE ahead of any handshake, and DONE is a single-cycle pulse in FIN.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_adr_q   <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START && !ABORT) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (ABORT) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            tx_data_q  <= RD_DATA;
            tx_adr_q   <= w_cur;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (ABORT) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (TX_READY) begin
            tx_valid_q <= 1'b0;
            if (w_at_last) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // The walk address doubles as the register-file read address and simply
  // holds its last value once the walker is idle.
  assign RD_ADR   = w_cur;
  assign TX_DATA  = tx_data_q;
  assign TX_ADR   = tx_adr_q;
  assign TX_VALID = tx_valid_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module     : tb_rf_snapshot_reader
// Description: Self-checking bench for rf_snapshot_reader with a behavioural
//              register file and an address-range reference model.
// Revision   : 1.0
// ============================================================================
module tb_rf_snapshot_reader;

  logic       clk = 1'b0;
  logic       RST_N;
  logic       START, ABORT, TX_READY;
  logic [4:0] FIRST_ADR, LAST_ADR, RD_ADR, TX_ADR;
  logic [7:0] RD_DATA, TX_DATA;
  logic       TX_VALID, BUSY, DONE;

  // Behavioural register file: writes land at the clock edge, reads are
  // combinational.
  logic [7:0] rf [32];
  logic       we;
  logic [4:0] wa;
  logic [7:0] wd;
  logic [7:0] model_rf [32];

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (we) rf[wa] <= wd;
  assign RD_DATA = rf[RD_ADR];

  rf_snapshot_reader dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .FIRST_ADR (FIRST_ADR),
    .LAST_ADR  (LAST_ADR),
    .RD_ADR    (RD_ADR),
    .RD_DATA   (RD_DATA),
    .TX_DATA   (TX_DATA),
    .TX_ADR    (TX_ADR),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    model_rf[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Issue a one-cycle START; FIRST/LAST are scrambled afterwards so that a
  // design which fails to latch them shows up.
  task automatic kick(input logic [4:0] f, input logic [4:0] l, output int sc);
    FIRST_ADR = f; LAST_ADR = l; START = 1'b1;
    sc = cyc;
    @(negedge clk);
    START = 1'b0;
    FIRST_ADR = ~f;
    LAST_ADR  = 5'($urandom_range(31, 0));
  endtask

  // Drive the sink and compare the stream with the model: byte k comes from
  // address (f+k) mod 32, n = ((l-f) mod 32)+1 bytes, then exactly one DONE.
  task automatic monitor(input logic [4:0] f, input logic [4:0] l, input int smin,
                         input int smax, input int sc, output int got, output int span);
    int n, done_cnt, stall_left, budget;
    logic hold, stable_ok;
    logic [7:0] hd;
    logic [4:0] ha, ea;
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    got = 0; done_cnt = 0; span = 0; hold = 1'b0; stable_ok = 1'b1; hd = '0; ha = '0;
    stall_left = int'($urandom_range(smax, smin));
    for (budget = 0; budget < 3000; budget++) begin
      if (!BUSY) break;
      if (DONE) done_cnt++;
      if (TX_VALID) begin
        if (hold && (TX_DATA !== hd || TX_ADR !== ha)) stable_ok = 1'b0;
        if (stall_left > 0) begin
          TX_READY = 1'b0; stall_left--; hold = 1'b1; hd = TX_DATA; ha = TX_ADR;
        end else begin
          TX_READY = 1'b1; hold = 1'b0;
          if (got < n) begin
            ea = f + 5'(got);
            check("byte address", 32'(TX_ADR), 32'(ea));
            check("byte data", 32'(TX_DATA), 32'(model_rf[ea]));
          end else begin
            check("extra byte count", 32'(got + 1), 32'(n));
          end
          got++;
          span = cyc - sc;
          stall_left = int'($urandom_range(smax, smin));
        end
      end else begin
        if (hold) stable_ok = 1'b0;
        hold = 1'b0;
        TX_READY = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
    end
    TX_READY = 1'b0;
    check("dump terminated (BUSY low)", 32'(BUSY), 32'd0);
    check("byte count", 32'(got), 32'(n));
    check("DONE pulses", 32'(done_cnt), 32'd1);
    check("TX held stable under backpressure", 32'(stable_ok), 32'd1);
    check("RD_ADR holds last address", 32'(RD_ADR), 32'(l));
  endtask

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int smin,
                          input int smax, output int got, output int span);
    int sc;
    kick(f, l, sc);
    monitor(f, l, smin, smax, sc, got, span);
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         smin;
    int         smax;
    int         exp_n;
  } vec_t;

  vec_t vt [6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, span, sc, k;
    logic [4:0] a;

    vt[0] = '{f: 5'd0,  l: 5'd31, smin: 0, smax: 0, exp_n: 32};
    vt[1] = '{f: 5'd30, l: 5'd1,  smin: 0, smax: 0, exp_n: 4};
    vt[2] = '{f: 5'd3,  l: 5'd8,  smin: 5, smax: 5, exp_n: 6};
    vt[3] = '{f: 5'd7,  l: 5'd7,  smin: 0, smax: 0, exp_n: 1};
    vt[4] = '{f: 5'd31, l: 5'd0,  smin: 1, smax: 2, exp_n: 2};
    vt[5] = '{f: 5'd5,  l: 5'd4,  smin: 0, smax: 1, exp_n: 32};

    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; TX_READY = 1'b0;
    FIRST_ADR = '0; LAST_ADR = '0; we = 1'b0; wa = '0; wd = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {RD_ADR, TX_DATA, TX_ADR, TX_VALID, BUSY, DONE}, 32'd0);
    RST_N = 1'b1;
    @(negedge clk);

    // Preload r_i = A0 + i.
    for (int i = 0; i < 32; i++) rf_write(5'(i), 8'(8'hA0 + i));

    // Table: ranges, wrap, single register, backpressure.
    for (int i = 0; i < 6; i++) begin
      run_dump(vt[i].f, vt[i].l, vt[i].smin, vt[i].smax, got, span);
      check("table byte count", 32'(got), 32'(vt[i].exp_n));
      if (vt[i].smax == 0) check("full-rate span START->last accept", 32'(span), 32'(2 * vt[i].exp_n));
    end

    // ABORT alone in IDLE, and ABORT together with START in IDLE.
    ABORT = 1'b1;
    @(negedge clk);
    check("ABORT in IDLE keeps BUSY low", 32'(BUSY), 32'd0);
    START = 1'b1; FIRST_ADR = 5'd2; LAST_ADR = 5'd3;
    @(negedge clk);
    check("ABORT beats START in IDLE", 32'({BUSY, TX_VALID}), 32'd0);
    START = 1'b0; ABORT = 1'b0;
    @(negedge clk);

    // Coherence: a write on the fetch edge is not seen; later writes leave the byte alone.
    rf_write(5'd5, 8'h11);
    FIRST_ADR = 5'd5; LAST_ADR = 5'd5; START = 1'b1; TX_READY = 1'b0;
    @(negedge clk);
    START = 1'b0; we = 1'b1; wa = 5'd5; wd = 8'h3C;
    @(negedge clk);
    wd = 8'h77;
    check("fetch-edge write: TX_VALID", 32'(TX_VALID), 32'd1);
    check("fetch-edge write: old value captured", 32'(TX_DATA), 32'h11);
    @(negedge clk);
    we = 1'b0; model_rf[5] = 8'h77;
    check("later write: byte unchanged", 32'({TX_ADR, TX_DATA}), 32'({5'd5, 8'h11}));
    TX_READY = 1'b1;
    @(negedge clk);
    TX_READY = 1'b0;
    check("single byte DONE", 32'(DONE), 32'd1);
    @(negedge clk);
    check("back to idle", 32'({BUSY, DONE}), 32'd0);

    // ABORT during SEND of byte 3.
    kick(5'd0, 5'd9, sc);
    k = 0;
    for (int b = 0; b < 200; b++) begin
      if (TX_VALID && TX_ADR == 5'd3) break;
      TX_READY = 1'b1;
      if (TX_VALID) k++;
      @(negedge clk);
    end
    check("bytes before abort", 32'(k), 32'd3);
    check("abort point reached with byte 3 valid", 32'({TX_VALID, TX_ADR}), 32'({1'b1, 5'd3}));
    ABORT = 1'b1; TX_READY = 1'b1;
    @(negedge clk);
    ABORT = 1'b0; TX_READY = 1'b0;
    check("abort: TX_VALID/BUSY/DONE", 32'({TX_VALID, BUSY, DONE}), 32'd0);
    @(negedge clk);
    check("abort: no late DONE", 32'({BUSY, DONE}), 32'd0);
    run_dump(5'd0, 5'd9, 0, 1, got, span);

    // Asynchronous reset mid-dump, between edges.
    kick(5'd0, 5'd31, sc);
    TX_READY = 1'b1;
    repeat (6) @(negedge clk);
    #2 RST_N = 1'b0;
    #1 check("async reset clears outputs", {RD_ADR, TX_DATA, TX_ADR, TX_VALID, BUSY, DONE}, 32'd0);
    @(negedge clk);
    RST_N = 1'b1; TX_READY = 1'b0;
    @(negedge clk);
    check("after reset: idle, no DONE", 32'({BUSY, DONE, TX_VALID}), 32'd0);

    // START while busy is ignored; single-register range 7..7.
    kick(5'd7, 5'd7, sc);
    FIRST_ADR = 5'd0; LAST_ADR = 5'd31; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    monitor(5'd7, 5'd7, 2, 2, sc, got, span);
    @(negedge clk);

    // Randomised dumps against the reference model.
    for (int r = 0; r < 20; r++) begin
      for (int w = 0; w < 4; w++) begin
        a = 5'($urandom_range(31, 0));
        rf_write(a, 8'($urandom_range(255, 0)));
      end
      run_dump(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 0, 3, got, span);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
